// File: rtl/req_arbiter12.sv
// req_arbiter12: shares one downstream resource among 12 requesters using
//   fixed-priority (bit 11 highest) or round-robin selection, with a hold-time
//   limit and a one-cycle gap after every grant.
// Latency: grant is registered, 1 cycle after REQ is sampled in IDLE.
// Backpressure: none. A requester holds its grant by keeping REQ high, and
//   other requesters wait until the grant drops.
// Ports:
//   i_clk, i_rst_n   clock (rising edge) / asynchronous active-low reset
//   i_req[11:0]      level-sensitive requests, bit i = requester i
//   i_mode           0 = fixed priority, 1 = round robin (sampled in IDLE)
//   o_gnt[11:0]      registered one-hot grant
//   o_gnt_id[3:0]    index of the granted requester; held after release
//   o_gnt_valid      high while a grant is asserted
//   o_timeout        one-cycle pulse when MAX_HOLD revokes a grant
module req_arbiter12 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_req,
  input  logic        i_mode,
  output logic [11:0] o_gnt,
  output logic [3:0]  o_gnt_id,
  output logic        o_gnt_valid,
  output logic        o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

  state_t             r_state;
  logic [11:0]        r_gnt;
  logic [3:0]         r_gnt_id;
  logic               r_gnt_valid;
  logic               r_timeout;
  logic [3:0]         r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [11:0]        r_mask;

  state_t             w_state_nxt;
  logic [11:0]        w_gnt_nxt;
  logic [3:0]         w_gnt_id_nxt;
  logic               w_gnt_valid_nxt;
  logic               w_timeout_nxt;
  logic [3:0]         w_last_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [11:0]        w_mask_set;
  logic [11:0]        w_mask_nxt;

  logic [11:0]        w_elig;
  logic [3:0]         w_win_fix;
  logic [3:0]         w_win_rr;
  logic [3:0]         w_win;
  logic [3:0]         w_idx;

  // Winner selection. Both loops let the preferred candidate overwrite
  // earlier ones: fixed mode ends on the highest set bit; round robin walks
  // the search order backwards so the first index of LAST-1, LAST-2, ...
  // (mod 12) with a set bit is the one that survives.
  always_comb begin
    w_elig    = i_req & ~r_mask;
    w_win_fix = 4'd0;
    w_win_rr  = 4'd0;
    w_idx     = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (w_elig[i]) w_win_fix = 4'(i);
    end
    for (int k = 12; k >= 1; k--) begin
      // (r_last - k) mod 12 without a divider; r_last never exceeds 11
      w_idx = (r_last >= 4'(k)) ? (r_last - 4'(k)) : (r_last + 4'(12 - k));
      if (w_elig[w_idx]) w_win_rr = w_idx;
    end
    w_win = i_mode ? w_win_rr : w_win_fix;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    w_last_nxt      = r_last;
    w_cnt_nxt       = r_cnt;
    w_mask_set      = 12'd0;
    case (r_state)
      S_IDLE: begin
        if (|w_elig) begin
          w_gnt_nxt       = 12'd1 << w_win;
          w_gnt_id_nxt    = w_win;
          w_gnt_valid_nxt = 1'b1;
          w_last_nxt      = w_win;
          w_cnt_nxt       = CNT_W'(1);
          w_state_nxt     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!i_req[r_gnt_id]) begin
          w_gnt_nxt       = 12'd0;
          w_gnt_valid_nxt = 1'b0;
          w_state_nxt     = S_GAP;
        end else if ((MAX_HOLD != 0) && (r_cnt == CNT_W'(MAX_HOLD))) begin
          // Revoke; the one-hot grant doubles as the mask bit to set.
          w_gnt_nxt       = 12'd0;
          w_gnt_valid_nxt = 1'b0;
          w_timeout_nxt   = 1'b1;
          w_mask_set      = r_gnt;
          w_state_nxt     = S_GAP;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A dropped request clears its mask bit; the set only happens while the
    // same request is high, so the two never collide.
    w_mask_nxt = (r_mask & i_req) | w_mask_set;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= 12'd0;
      r_gnt_id    <= 4'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_last      <= 4'd0;
      r_cnt       <= '0;
      r_mask      <= 12'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mask      <= w_mask_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_id    = r_gnt_id;
  assign o_gnt_valid = r_gnt_valid;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_req_arbiter12.sv
// tb_req_arbiter12: self-checking bench for req_arbiter12 (vector table,
//   hand-written corner sequences, random traffic against a behavioural model).
// Inputs change 1 ns after the rising edge; outputs are compared there too.
module tb_req_arbiter12;
  localparam int MAXH = 16;
  localparam int CMAX = 31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] req = 12'd0;
  logic        mode = 1'b0;
  logic [11:0] o_gnt;
  logic [3:0]  o_gnt_id;
  logic        o_gnt_valid;
  logic        o_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  req_arbiter12 #(.MAX_HOLD(MAXH), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_mode(mode),
    .o_gnt(o_gnt), .o_gnt_id(o_gnt_id), .o_gnt_valid(o_gnt_valid),
    .o_timeout(o_timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: who owns the resource (-1 = nobody), how long, and
  // whether the mandatory gap cycle is pending.
  int          m_owner = -1;
  int          m_hold  = 0;
  int          m_gap   = 0;
  int          m_last  = 0;
  int          m_id    = 0;
  bit          m_to    = 1'b0;
  logic [11:0] m_mask  = 12'd0;

  task automatic model_reset();
    m_owner = -1; m_hold = 0; m_gap = 0; m_last = 0; m_id = 0;
    m_to = 1'b0; m_mask = 12'd0;
  endtask

  task automatic model_step(input logic [11:0] r, input logic md);
    logic [11:0] elig;
    logic [11:0] setm;
    int w;
    elig = r & ~m_mask;
    setm = 12'd0;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (MAXH != 0 && m_hold == MAXH) begin
        setm[m_owner] = 1'b1; m_to = 1'b1; m_owner = -1; m_gap = 1;
      end else if (m_hold < CMAX) begin
        m_hold++;
      end
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (elig != 12'd0) begin
      w = -1;
      if (!md) begin
        for (int i = 11; i >= 0; i--) if (elig[i]) begin w = i; break; end
      end else begin
        for (int k = 1; k <= 12; k++) begin
          int j;
          j = (m_last - k + 12) % 12;
          if (elig[j]) begin w = j; break; end
        end
      end
      m_owner = w; m_id = w; m_last = w; m_hold = 1;
    end
    m_mask = (m_mask & r) | setm;
  endtask

  function automatic logic [11:0] m_gnt();
    return (m_owner >= 0) ? (12'd1 << m_owner) : 12'd0;
  endfunction

  task automatic tick();
    if (rst_n) model_step(req, mode);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_gnt"}, int'(o_gnt), int'(m_gnt()));
    chk({tag, "_id"}, int'(o_gnt_id), m_id);
    chk({tag, "_vld"}, int'(o_gnt_valid), int'(m_owner >= 0));
    chk({tag, "_to"}, int'(o_timeout), int'(m_to));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 12'd0; mode = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string name, input int budget, output int n);
    n = 0;
    while (!o_gnt_valid && n < budget) begin tick(); n++; end
    chk(name, int'(o_gnt_valid), 1);
  endtask

  typedef struct {
    logic [11:0] req;
    logic        mode;
    logic [11:0] gnt;
    int          id;
    logic        vld;
  } vec_t;

  vec_t tbl[11];
  int   rr_exp[4];

  initial begin
    int n, h, prev, seen_v, seen_t;
    logic [11:0] flip;

    // fixed priority, release/gap timing, request changes during a grant
    tbl[0]  = '{12'h810, 1'b0, 12'h800, 11, 1'b1};
    tbl[1]  = '{12'h010, 1'b0, 12'h000, 11, 1'b0};
    tbl[2]  = '{12'h010, 1'b0, 12'h000, 11, 1'b0};
    tbl[3]  = '{12'h010, 1'b0, 12'h010,  4, 1'b1};
    tbl[4]  = '{12'h810, 1'b0, 12'h010,  4, 1'b1};
    tbl[5]  = '{12'h810, 1'b0, 12'h010,  4, 1'b1};
    tbl[6]  = '{12'h800, 1'b0, 12'h000,  4, 1'b0};
    tbl[7]  = '{12'h800, 1'b0, 12'h000,  4, 1'b0};
    tbl[8]  = '{12'h800, 1'b0, 12'h800, 11, 1'b1};
    tbl[9]  = '{12'h000, 1'b0, 12'h000, 11, 1'b0};
    tbl[10] = '{12'h000, 1'b0, 12'h000, 11, 1'b0};
    rr_exp  = '{2, 0, 2, 0};

    do_reset();
    chk("rst_gnt", int'(o_gnt), 0);
    chk("rst_id", int'(o_gnt_id), 0);
    chk("rst_vld", int'(o_gnt_valid), 0);
    chk("rst_to", int'(o_timeout), 0);

    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req; mode = tbl[i].mode;
      tick();
      chk($sformatf("vec%0d_gnt", i), int'(o_gnt), int'(tbl[i].gnt));
      chk($sformatf("vec%0d_id", i), int'(o_gnt_id), tbl[i].id);
      chk($sformatf("vec%0d_vld", i), int'(o_gnt_valid), int'(tbl[i].vld));
      chk($sformatf("vec%0d_to", i), int'(o_timeout), 0);
    end

    // round robin between requesters 2 and 0
    do_reset();
    mode = 1'b1; req = 12'h005; prev = -1;
    for (int g = 0; g < 4; g++) begin
      wait_grant($sformatf("rr%0d_grant", g), 8, n);
      chk($sformatf("rr%0d_id", g), int'(o_gnt_id), rr_exp[g]);
      if (prev >= 0) chk($sformatf("rr%0d_not_repeat", g), int'(int'(o_gnt_id) != prev), 1);
      prev = int'(o_gnt_id);
      tick(); tick();
      req = 12'h005 & ~(12'd1 << prev);
      tick();
      req = 12'h005;
    end

    // hold-time limit
    do_reset();
    req = 12'h001;
    wait_grant("to_grant", 4, n);
    chk("to_latency", n, 1);
    h = 0;
    while (o_gnt_valid && h < 40) begin h++; tick(); end
    chk("to_hold_cycles", h, MAXH);
    chk("to_pulse", int'(o_timeout), 1);
    chk("to_gnt_cleared", int'(o_gnt), 0);
    tick();
    chk("to_pulse_one_cycle", int'(o_timeout), 0);
    seen_v = 0;
    for (int i = 0; i < 5; i++) begin tick(); seen_v |= int'(o_gnt_valid); end
    chk("to_no_regrant", seen_v, 0);
    req = 12'h000; tick();
    chk("to_drop_idle", int'(o_gnt_valid), 0);
    req = 12'h001; tick();
    chk("to_regrant_vld", int'(o_gnt_valid), 1);
    chk("to_regrant_id", int'(o_gnt_id), 0);

    // asynchronous reset in the middle of a grant
    do_reset();
    req = 12'h080;
    tick(); tick();
    chk("ar_pre_id", int'(o_gnt_id), 7);
    chk("ar_pre_vld", int'(o_gnt_valid), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_gnt", int'(o_gnt), 0);
    chk("ar_vld", int'(o_gnt_valid), 0);
    chk("ar_to", int'(o_timeout), 0);
    chk("ar_id", int'(o_gnt_id), 0);
    tick();
    rst_n = 1'b1; mode = 1'b1; req = 12'h080;
    tick();
    chk("ar_regrant_vld", int'(o_gnt_valid), 1);
    chk("ar_regrant_id", int'(o_gnt_id), 7);

    // no requests at all
    do_reset();
    seen_v = 0; seen_t = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); seen_v |= int'(o_gnt_valid); seen_t |= int'(o_timeout);
    end
    chk("idle_vld", seen_v, 0);
    chk("idle_to", seen_t, 0);

    // random traffic against the model
    do_reset();
    req = 12'd0;
    for (int c = 0; c < 3000; c++) begin
      flip = 12'($urandom & $urandom & $urandom & $urandom);
      req = req ^ flip;
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before 2000000 ns");
    $fatal(1, "watchdog");
  end

endmodule
